// File: rtl/mio_bus_responder_pkg.sv
// Shared definitions for the CPU data-port responder: DMType codes, MMIO map,
// STATUS bit positions, FSM states and lane steering helpers.
package mio_bus_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [15:0] OFS_LED    = 16'h0000;
  localparam logic [15:0] OFS_SW     = 16'h0004;
  localparam logic [15:0] OFS_TCOUNT = 16'h0008;
  localparam logic [15:0] OFS_TCMP   = 16'h000C;
  localparam logic [15:0] OFS_STATUS = 16'h0010;

  localparam int STAT_EN  = 0;
  localparam int STAT_IRQ = 1;
  localparam int STAT_MIS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_half(input logic [2:0] dm);
    return (dm == DM_HALF_S) || (dm == DM_HALF_U);
  endfunction

  function automatic logic is_byte(input logic [2:0] dm);
    return (dm == DM_BYTE_S) || (dm == DM_BYTE_U);
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] dm);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (dm)
      DM_HALF_S: res = {{16{h[15]}}, h};
      DM_HALF_U: res = {16'h0000, h};
      DM_BYTE_S: res = {{24{b[7]}}, b};
      DM_BYTE_U: res = {24'h000000, b};
      default:   res = w;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] a, input logic [2:0] dm);
    logic [3:0] be;
    if (is_half(dm))      be = a[1] ? 4'b1100 : 4'b0011;
    else if (is_byte(dm)) be = 4'b0001 << a;
    else                  be = 4'b1111;
    return be;
  endfunction

  // Store data arrives right-aligned; replicate it so every lane carries it.
  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] dm);
    logic [31:0] res;
    if (is_half(dm))      res = {2{wd[15:0]}};
    else if (is_byte(dm)) res = {4{wd[7:0]}};
    else                  res = wd;
    return res;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Compare-match timer: free-running count while enabled, wraps on match with TCMP
// and latches irq_pend; a clear in the same cycle as a match loses to the match.
module mio_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmp_we,
  input  logic [31:0] i_cmp_dat,
  input  logic        i_ctrl_we,
  input  logic        i_en_dat,
  input  logic        i_irq_clr,
  output logic [31:0] o_count,
  output logic [31:0] o_cmp,
  output logic        o_en,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_irq;
  logic        w_match;

  assign w_match = r_en && (r_count == r_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'h0;
      r_cmp   <= 32'h0;
      r_en    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (i_cmp_we)  r_cmp <= i_cmp_dat;
      if (i_ctrl_we) r_en  <= i_en_dat;
      if (w_match)   r_count <= 32'h0;
      else if (r_en) r_count <= r_count + 32'h1;
      r_irq <= (r_irq & ~i_irq_clr) | w_match;
    end
  end

  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_en    = r_en;
  assign o_irq   = r_irq;

endmodule

// File: rtl/mio_bus_responder.sv
// CPU data-port responder: data RAM with byte enables, MMIO registers and a
// compare-match timer, completed through an IDLE -> WAIT -> RESP handshake.
module mio_bus_responder
  import mio_bus_responder_pkg::*;
#(
  parameter int          RAM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        int_out
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_mem [0:RAM_WORDS-1];

  state_e      r_state;
  logic [3:0]  r_wcnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_dm;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic        r_misalign;

  logic [31:0]   w_addr;
  logic [2:0]    w_dm;
  logic          w_is_ram;
  logic          w_is_mmio;
  logic          w_half;
  logic          w_byte;
  logic          w_misalign;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_ram_rd;
  logic [31:0]   w_mmio_rd;
  logic [31:0]   w_load;
  logic          w_commit;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic          w_cmp_we;
  logic          w_stat_we;
  logic [31:0]   w_tcount;
  logic [31:0]   w_tcmp;
  logic          w_ten;
  logic          w_tirq;

  // In IDLE the live request is decoded so a zero-wait load can be answered at once.
  assign w_addr = (r_state == ST_IDLE) ? cpu_addr : r_addr;
  assign w_dm   = (r_state == ST_IDLE) ? cpu_dmtype : r_dm;

  assign w_is_ram   = (w_addr[31:AW+2] == '0);
  assign w_is_mmio  = (w_addr[31:16] == MMIO_BASE[31:16]);
  assign w_half     = !w_is_mmio && is_half(w_dm);
  assign w_byte     = !w_is_mmio && is_byte(w_dm);
  assign w_misalign = w_half ? w_addr[0] : (w_byte ? 1'b0 : (w_addr[1:0] != 2'b00));
  assign w_idx      = w_addr[AW+1:2];
  assign w_ram_rd   = r_mem[w_idx];

  always_comb begin
    w_mmio_rd = 32'h0;
    case (w_addr[15:0])
      OFS_LED:    w_mmio_rd = {16'h0000, r_led};
      OFS_SW:     w_mmio_rd = {16'h0000, sw_in};
      OFS_TCOUNT: w_mmio_rd = w_tcount;
      OFS_TCMP:   w_mmio_rd = w_tcmp;
      OFS_STATUS: w_mmio_rd = {29'h0, r_misalign, w_tirq, w_ten};
      default:    w_mmio_rd = 32'h0;
    endcase
  end

  always_comb begin
    w_load = 32'h0;
    if (!w_misalign) begin
      if (w_is_ram)       w_load = load_lane(w_ram_rd, w_addr[1:0], w_dm);
      else if (w_is_mmio) w_load = w_mmio_rd;
    end
  end

  assign w_commit  = (r_state == ST_RESP) && r_we && !w_misalign;
  assign w_ram_we  = w_commit && w_is_ram;
  assign w_mmio_we = w_commit && w_is_mmio;
  assign w_be      = store_be(w_addr[1:0], w_dm);
  assign w_wd      = store_data(r_wdata, w_dm);
  assign w_cmp_we  = w_mmio_we && (w_addr[15:0] == OFS_TCMP);
  assign w_stat_we = w_mmio_we && (w_addr[15:0] == OFS_STATUS);

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_dm    <= DM_WORD;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_we    <= cpu_we;
            r_dm    <= cpu_dmtype;
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
              r_rdata <= cpu_we ? 32'h0 : w_load;
            end else begin
              r_state <= ST_WAIT;
              r_wcnt  <= 4'(WAIT_STATES);
            end
          end
        end
        ST_WAIT: begin
          if (r_wcnt == 4'd1) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
            r_rdata <= r_we ? 32'h0 : w_load;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led      <= 16'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_mmio_we && (w_addr[15:0] == OFS_LED)) r_led <= r_wdata[15:0];
      if ((r_state == ST_RESP) && w_misalign)    r_misalign <= 1'b1;
      else if (w_stat_we && r_wdata[STAT_MIS])   r_misalign <= 1'b0;
    end
  end

  mio_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_cmp_we  (w_cmp_we),
    .i_cmp_dat (r_wdata),
    .i_ctrl_we (w_stat_we),
    .i_en_dat  (r_wdata[STAT_EN]),
    .i_irq_clr (w_stat_we && r_wdata[STAT_IRQ]),
    .o_count   (w_tcount),
    .o_cmp     (w_tcmp),
    .o_en      (w_ten),
    .o_irq     (w_tirq)
  );

  assign cpu_ready = r_ready;
  assign cpu_rdata = r_rdata;
  assign led_out   = r_led;
  assign int_out   = w_tirq;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: a zero-wait and a three-wait-state instance share
// one clock; load results are scoreboarded and popped on each ready pulse.
module tb_mio_bus_responder;

  localparam logic [31:0] MB     = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = MB + 32'h00;
  localparam logic [31:0] A_SW   = MB + 32'h04;
  localparam logic [31:0] A_TCNT = MB + 32'h08;
  localparam logic [31:0] A_TCMP = MB + 32'h0C;
  localparam logic [31:0] A_STAT = MB + 32'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, req, we, ready, irq;
  logic [1:0][31:0]  addr, wdata, rdata;
  logic [1:0][2:0]   dm;
  logic [1:0][15:0]  sw, led;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qe[$];
  string       qn[$];

  mio_bus_responder #(.RAM_WORDS(1024), .WAIT_STATES(0), .MMIO_BASE(MB)) u_d0 (
    .clk(clk), .rst(rst[0]), .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]),
    .cpu_wdata(wdata[0]), .cpu_dmtype(dm[0]), .cpu_rdata(rdata[0]), .cpu_ready(ready[0]),
    .sw_in(sw[0]), .led_out(led[0]), .int_out(irq[0])
  );

  mio_bus_responder #(.RAM_WORDS(1024), .WAIT_STATES(3), .MMIO_BASE(MB)) u_d1 (
    .clk(clk), .rst(rst[1]), .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]),
    .cpu_wdata(wdata[1]), .cpu_dmtype(dm[1]), .cpu_rdata(rdata[1]), .cpu_ready(ready[1]),
    .sw_in(sw[1]), .led_out(led[1]), .int_out(irq[1])
  );

  // Called at a negedge; returns at the negedge after the access has fully retired.
  task automatic access(input bit d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] t, input logic [31:0] e,
                        input string nm, output int lat);
    logic [31:0] ex;
    string       n;
    if (!w) begin
      qe.push_back(e);
      qn.push_back(nm);
    end
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; dm[d] = t;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ready[d] !== 1'b1 && lat < 40);
    if (ready[d] !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s: no ready within %0d cycles", nm, lat);
      if (!w) begin
        ex = qe.pop_front();
        n  = qn.pop_front();
      end
    end else if (!w) begin
      ex = qe.pop_front();
      n  = qn.pop_front();
      checks++;
      if (rdata[d] !== ex) begin
        failures++;
        $display("FAIL %s: rdata=%08h expected %08h", n, rdata[d], ex);
      end
    end
    req[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ready[d], irq[d], led[d], rdata[d]} !== 50'h0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: ready=%b int=%b led=%04h rdata=%08h expected all 0",
                 d, ready[d], irq[d], led[d], rdata[d]);
      end
    end
    access(0, 0, A_TCNT, 0, 3'b000, 32'h0, "reset_tcount", lat);
    access(0, 0, A_STAT, 0, 3'b000, 32'h0, "reset_status", lat);
  endtask

  task automatic test_word();
    int lat;
    access(0, 1, 32'h10, 32'h12345678, 3'b000, 0, "sw_word", lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL store_latency: %0d cycles expected 1", lat); end
    access(0, 0, 32'h10, 0, 3'b000, 32'h12345678, "lw_word", lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL load_latency: %0d cycles expected 1", lat); end
  endtask

  task automatic test_subword();
    int lat;
    access(0, 1, 32'h13, 32'h000000AA, 3'b011, 0, "sb", lat);
    access(0, 0, 32'h10, 0, 3'b000, 32'hAA345678, "lw_after_sb", lat);
    access(0, 0, 32'h13, 0, 3'b011, 32'hFFFFFFAA, "lb", lat);
    access(0, 0, 32'h13, 0, 3'b100, 32'h000000AA, "lbu", lat);
    access(0, 0, 32'h12, 0, 3'b001, 32'hFFFFAA34, "lh", lat);
    access(0, 0, 32'h12, 0, 3'b010, 32'h0000AA34, "lhu", lat);
    access(0, 1, 32'h40, 32'hCAFEF00D, 3'b000, 0, "sw_40", lat);
    access(0, 1, 32'h40, 32'h00001234, 3'b001, 0, "sh_40", lat);
    access(0, 0, 32'h40, 0, 3'b000, 32'hCAFE1234, "lw_after_sh", lat);
    access(0, 0, 32'h40, 0, 3'b111, 32'hCAFE1234, "lw_dm_other", lat);
  endtask

  task automatic test_misalign();
    int lat;
    access(0, 0, 32'h11, 0, 3'b000, 32'h0, "lw_misaligned", lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL misalign_ready: %0d cycles expected 1", lat); end
    access(0, 0, A_STAT, 0, 3'b000, 32'h4, "status_misalign", lat);
    access(0, 1, 32'h11, 32'hFFFFFFFF, 3'b000, 0, "sw_misaligned", lat);
    access(0, 1, 32'h13, 32'h0000FFFF, 3'b001, 0, "sh_misaligned", lat);
    access(0, 0, 32'h10, 0, 3'b000, 32'hAA345678, "ram_intact", lat);
    access(0, 1, A_STAT, 32'h4, 3'b000, 0, "status_w1c", lat);
    access(0, 0, A_STAT, 0, 3'b000, 32'h0, "status_cleared", lat);
  endtask

  task automatic test_timer();
    int lat;
    access(0, 1, A_TCMP, 32'h5, 3'b000, 0, "tcmp_write", lat);
    access(0, 0, A_TCMP, 0, 3'b000, 32'h5, "tcmp_read", lat);
    access(0, 1, A_STAT, 32'h1, 3'b000, 0, "timer_enable", lat);
    repeat (5) @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin failures++; $display("FAIL irq_before_match: int=%b expected 0", irq[0]); end
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b1) begin failures++; $display("FAIL irq_at_match: int=%b expected 1", irq[0]); end
    // Timed so the W1C commits on the same edge as the next compare match.
    repeat (4) @(negedge clk);
    access(0, 1, A_STAT, 32'h3, 3'b000, 0, "w1c_on_match", lat);
    checks++;
    if (irq[0] !== 1'b1) begin failures++; $display("FAIL irq_w1c_on_match: int=%b expected 1", irq[0]); end
    access(0, 1, A_STAT, 32'h2, 3'b000, 0, "disable_and_clear", lat);
    checks++;
    if (irq[0] !== 1'b0) begin failures++; $display("FAIL irq_cleared: int=%b expected 0", irq[0]); end
    access(0, 0, A_TCNT, 0, 3'b000, 32'h2, "tcount_frozen_a", lat);
    access(0, 0, A_TCNT, 0, 3'b000, 32'h2, "tcount_frozen_b", lat);
    access(0, 0, A_STAT, 0, 3'b000, 32'h0, "status_after_timer", lat);
  endtask

  task automatic test_mmio();
    int lat;
    access(0, 1, A_LED, 32'h0000BEEF, 3'b000, 0, "led_write", lat);
    checks++;
    if (led[0] !== 16'hBEEF) begin failures++; $display("FAIL led_out: %04h expected beef", led[0]); end
    sw[0] = 16'h00F0;
    access(0, 0, A_SW, 0, 3'b000, 32'h000000F0, "sw_read", lat);
    access(0, 1, A_SW, 32'hFFFFFFFF, 3'b000, 0, "sw_ro_write", lat);
    access(0, 0, A_SW, 0, 3'b000, 32'h000000F0, "sw_read_after_write", lat);
    access(0, 0, A_LED, 0, 3'b011, 32'h0000BEEF, "led_byte_as_word", lat);
    access(0, 0, 32'h8000_0000, 0, 3'b000, 32'h0, "unmapped_load", lat);
    access(0, 1, 32'h8000_0000, 32'h55555555, 3'b000, 0, "unmapped_store", lat);
    access(0, 0, 32'h8000_0000, 0, 3'b000, 32'h0, "unmapped_reload", lat);
  endtask

  task automatic test_wait_states();
    int lat;
    bit seen;
    access(1, 1, 32'h20, 32'h11111111, 3'b000, 0, "ws3_store", lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws3_store_latency: %0d cycles expected 4", lat); end
    access(1, 0, 32'h20, 0, 3'b000, 32'h11111111, "ws3_load", lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws3_load_latency: %0d cycles expected 4", lat); end
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEADBEEF; dm[1] = 3'b000;
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    req[1] = 1'b0; we[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[1] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL ready_after_abort: ready seen=1 expected 0"); end
    rst[1] = 1'b0;
    @(negedge clk);
    access(1, 0, 32'h20, 0, 3'b000, 32'h11111111, "ram_after_abort", lat);
  endtask

  initial begin
    rst = 2'b11; req = '0; we = '0; addr = '0; wdata = '0; dm = '0; sw = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_timer();
    test_mmio();
    test_wait_states();
    checks++;
    if (qe.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", qe.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
